// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared constants and types for the hazard/forwarding controller.
//   - FWD_RF / FWD_W / FWD_M : operand forward-select encodings
//   - RESULT_LOAD            : ResultSrc encoding that marks a load in E
//   - mdu_state_e            : state of the MDU stall engine (IDLE/BUSY)
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_stall_ctr.sv
// mdu_stall_ctr
//   Stall engine for the multi-cycle MDU sitting in E. A start seen in IDLE
//   stalls immediately and loads a down-counter; the stall is held while the
//   counter is nonzero, so the MDU instruction occupies E for exactly MDU_LAT
//   cycles when memory does not stall. If memory is waiting when the count
//   expires, the engine parks in BUSY (count 0, no MDU stall) until M frees up.
// Parameters:
//   MDU_LAT : cycles an MDU op occupies E, legal range 2..64
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : E holds an MDU instruction (level); ignored while BUSY
//   mw         : data memory wait in M
//   ms         : MDU stall request (combinational)
//   busy       : engine is in BUSY (state exposure)
module mdu_stall_ctr
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mw,
  output logic ms,
  output logic busy
);

  localparam int CW = $clog2(MDU_LAT);
  // The start cycle itself is one stall cycle, so BUSY counts the rest.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 2);

  mdu_state_e    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          // Counting continues through memory waits; only the exit waits on M.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!mw) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Gating with rst_n makes the stall drop the instant reset asserts, even if
  // the datapath still presents a held start.
  always_comb begin
    ms = 1'b0;
    if (rst_n) begin
      if (state == IDLE) ms = start;
      else               ms = (cnt != '0);
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard and forwarding controller for the 5-stage RV32 pipeline F/D/E/M/W.
//   Forwards from M/W, stalls on load-use, stalls E for a multi-cycle MDU and
//   M for variable-latency data memory, and flushes on taken branches only
//   when E actually advances.
//   Priority of causes: memory wait > MDU stall > load-use > redirect.
// Parameters:
//   REG_AW  : register address width
//   MDU_LAT : cycles an MDU op occupies E (2..64)
// Ports:
//   clk_i, rst_n_i                   : clock, asynchronous active-low reset
//   RS_addrD_i, RT_addrD_i           : D-stage sources
//   RS_addrE_i, RT_addrE_i, RD_addrE_i : E-stage sources / destination
//   ResultSrcE_i                     : E result select (01 = load)
//   PC_SrcE_i                        : branch/jump taken in E
//   MduStartE_i                      : E holds an MDU op (level)
//   RD_addrM_i, RegWriteM_i          : M writeback info
//   MemReqM_i, MemReadyM_i           : M memory request / completion
//   RD_addrW_i, RegWriteW_i          : W writeback info
//   Stall{F,D,E,M}_o                 : hold stage registers
//   Flush{D,E,M,W}_o                 : bubble into stage registers
//   RedirectE_o                      : PC mux may take the branch target
//   Forward1E_o, Forward2E_o         : 00 RF, 01 W result, 10 M ALU result
//   MduBusy_o                        : MDU engine in BUSY
// Optional build macro HAZARD_PERF_CNT_EN adds 32-bit wrapping counters:
//   LoadStallCnt_o, MduStallCnt_o, MemStallCnt_o, FlushCnt_o
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] RS_addrD_i,
  input  logic [REG_AW-1:0] RT_addrD_i,
  input  logic [REG_AW-1:0] RS_addrE_i,
  input  logic [REG_AW-1:0] RT_addrE_i,
  input  logic [REG_AW-1:0] RD_addrE_i,
  input  logic [1:0]        ResultSrcE_i,
  input  logic              PC_SrcE_i,
  input  logic              MduStartE_i,
  input  logic [REG_AW-1:0] RD_addrM_i,
  input  logic              RegWriteM_i,
  input  logic              MemReqM_i,
  input  logic              MemReadyM_i,
  input  logic [REG_AW-1:0] RD_addrW_i,
  input  logic              RegWriteW_i,
  output logic              StallF_o,
  output logic              StallD_o,
  output logic              StallE_o,
  output logic              StallM_o,
  output logic              FlushD_o,
  output logic              FlushE_o,
  output logic              FlushM_o,
  output logic              FlushW_o,
  output logic              RedirectE_o,
  output logic [1:0]        Forward1E_o,
  output logic [1:0]        Forward2E_o,
  output logic              MduBusy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       LoadStallCnt_o,
  output logic [31:0]       MduStallCnt_o,
  output logic [31:0]       MemStallCnt_o,
  output logic [31:0]       FlushCnt_o
`endif
);

  // M wins over W because it holds the younger write of the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] s,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (s != '0) begin
      if (we_m && (s == rd_m))      sel = FWD_M;
      else if (we_w && (s == rd_w)) sel = FWD_W;
    end
    return sel;
  endfunction

  logic lu;   // load-use hazard between E and D
  logic mw;   // data memory wait in M
  logic ms;   // MDU stall request

  assign Forward1E_o = fwd_sel(RS_addrE_i, RD_addrM_i, RegWriteM_i, RD_addrW_i, RegWriteW_i);
  assign Forward2E_o = fwd_sel(RT_addrE_i, RD_addrM_i, RegWriteM_i, RD_addrW_i, RegWriteW_i);

  // Only real loads stall; other non-ALU results are already available in M.
  assign lu = (ResultSrcE_i == RESULT_LOAD) && (RD_addrE_i != '0) &&
              ((RD_addrE_i == RS_addrD_i) || (RD_addrE_i == RT_addrD_i));

  assign mw = MemReqM_i & ~MemReadyM_i;

  mdu_stall_ctr #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_stall_ctr (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .start (MduStartE_i),
    .mw    (mw),
    .ms    (ms),
    .busy  (MduBusy_o)
  );

  assign StallM_o = mw;
  assign FlushW_o = mw;
  assign StallE_o = mw | ms;
  // While M is frozen by memory it must keep its instruction, not take a bubble.
  assign FlushM_o = ms & ~mw;
  assign StallD_o = mw | ms | lu;
  assign StallF_o = mw | ms | lu;

  // A branch frozen in E redirects only in the cycle E advances, so the
  // redirect fires exactly once.
  assign RedirectE_o = PC_SrcE_i & ~StallE_o;
  assign FlushD_o    = RedirectE_o;
  assign FlushE_o    = RedirectE_o | (lu & ~StallE_o);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      LoadStallCnt_o <= '0;
      MduStallCnt_o  <= '0;
      MemStallCnt_o  <= '0;
      FlushCnt_o     <= '0;
    end else begin
      // Each stalled cycle is charged to its highest-priority cause only.
      if (lu & ~mw & ~ms) LoadStallCnt_o <= LoadStallCnt_o + 32'd1;
      if (ms & ~mw)       MduStallCnt_o  <= MduStallCnt_o + 32'd1;
      if (mw)             MemStallCnt_o  <= MemStallCnt_o + 32'd1;
      if (RedirectE_o)    FlushCnt_o     <= FlushCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc
//   Directed bench for hazard_unit_mc (REG_AW=5, MDU_LAT=4). Each driven cycle
//   pushes its hand-computed output vector; a monitor pops and compares at
//   the falling edge. Output vector layout (14 bits):
//   {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,Redirect,
//    Forward1E[1:0],Forward2E[1:0],MduBusy}
module tb_hazard_unit_mc;

  localparam int W = 14;

  // Control-field patterns, bit order StallF..Redirect.
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110001000;
  localparam logic [8:0] C_MS   = 9'b111000100;
  localparam logic [8:0] C_MW   = 9'b111100010;
  localparam logic [8:0] C_RDIR = 9'b000011001;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
  logic [1:0] res_src_e;
  logic       pc_src_e, mdu_start, reg_write_m, mem_req, mem_ready, reg_write_w;

  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w, redirect;
  logic [1:0] fwd1, fwd2;
  logic       mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] load_cnt, mdu_cnt, mem_cnt, flush_cnt;
`endif

  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;

  hazard_unit_mc #(
    .REG_AW  (5),
    .MDU_LAT (4)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .RS_addrD_i   (rs_d),
    .RT_addrD_i   (rt_d),
    .RS_addrE_i   (rs_e),
    .RT_addrE_i   (rt_e),
    .RD_addrE_i   (rd_e),
    .ResultSrcE_i (res_src_e),
    .PC_SrcE_i    (pc_src_e),
    .MduStartE_i  (mdu_start),
    .RD_addrM_i   (rd_m),
    .RegWriteM_i  (reg_write_m),
    .MemReqM_i    (mem_req),
    .MemReadyM_i  (mem_ready),
    .RD_addrW_i   (rd_w),
    .RegWriteW_i  (reg_write_w),
    .StallF_o     (stall_f),
    .StallD_o     (stall_d),
    .StallE_o     (stall_e),
    .StallM_o     (stall_m),
    .FlushD_o     (flush_d),
    .FlushE_o     (flush_e),
    .FlushM_o     (flush_m),
    .FlushW_o     (flush_w),
    .RedirectE_o  (redirect),
    .Forward1E_o  (fwd1),
    .Forward2E_o  (fwd2),
    .MduBusy_o    (mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .LoadStallCnt_o (load_cnt),
    .MduStallCnt_o  (mdu_cnt),
    .MemStallCnt_o  (mem_cnt),
    .FlushCnt_o     (flush_cnt)
`endif
  );

  assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
                flush_w, redirect, fwd1, fwd2, mdu_busy};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  function automatic logic [W-1:0] ev(input logic [8:0] ctl, input logic [1:0] f1,
                                      input logic [1:0] f2, input logic bz);
    return {ctl, f1, f2, bz};
  endfunction

  task automatic clear_in();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    res_src_e = 2'b00; pc_src_e = 1'b0; mdu_start = 1'b0; reg_write_m = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; reg_write_w = 1'b0;
  endtask

  // Inputs set before the call hold for one full cycle; expectation is queued.
  task automatic cyc(input string nm, input logic [W-1:0] e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_in();
    @(posedge clk);
    #1;

    // Reset state
    cyc("reset_hold", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    rst_n = 1'b1;
    cyc("reset_release", ev(C_NONE, 2'b00, 2'b00, 1'b0));
`ifdef HAZARD_PERF_CNT_EN
    check32("perf_load_reset", load_cnt, 32'd0);
    check32("perf_mdu_reset", mdu_cnt, 32'd0);
    check32("perf_mem_reset", mem_cnt, 32'd0);
    check32("perf_flush_reset", flush_cnt, 32'd0);
`endif

    // Forwarding
    rs_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
    cyc("fwd_m_over_w", ev(C_NONE, 2'b10, 2'b00, 1'b0));
    reg_write_m = 1'b0;
    cyc("fwd_w", ev(C_NONE, 2'b01, 2'b00, 1'b0));
    rs_e = 5'd0; rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd0;
    cyc("fwd_x0", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    rs_e = 5'd3; rt_e = 5'd9; rd_m = 5'd3; rd_w = 5'd9;
    cyc("fwd_split", ev(C_NONE, 2'b10, 2'b01, 1'b0));
    rs_e = 5'd12; rt_e = 5'd12; rd_m = 5'd13; rd_w = 5'd12; reg_write_w = 1'b0;
    cyc("fwd_none", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    clear_in();

    // Load-use
    res_src_e = 2'b01; rd_e = 5'd7; rt_d = 5'd7;
    cyc("lu_rt", ev(C_LU, 2'b00, 2'b00, 1'b0));
    clear_in();
    cyc("lu_after", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    res_src_e = 2'b11; rd_e = 5'd7; rt_d = 5'd7;
    cyc("lu_not_load", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    res_src_e = 2'b01; rd_e = 5'd0; rt_d = 5'd0; rs_d = 5'd0;
    cyc("lu_x0", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    rd_e = 5'd7; rs_d = 5'd7; rt_d = 5'd2;
    cyc("lu_rs", ev(C_LU, 2'b00, 2'b00, 1'b0));
    clear_in();

    // Taken branch, no hazard
    pc_src_e = 1'b1;
    cyc("branch", ev(C_RDIR, 2'b00, 2'b00, 1'b0));
    clear_in();

    // MDU, then back-to-back MDU
    mdu_start = 1'b1;
    cyc("mdu1_c1", ev(C_MS,   2'b00, 2'b00, 1'b0));
    cyc("mdu1_c2", ev(C_MS,   2'b00, 2'b00, 1'b1));
    cyc("mdu1_c3", ev(C_MS,   2'b00, 2'b00, 1'b1));
    cyc("mdu1_c4", ev(C_NONE, 2'b00, 2'b00, 1'b1));
    cyc("mdu2_c1", ev(C_MS,   2'b00, 2'b00, 1'b0));
    cyc("mdu2_c2", ev(C_MS,   2'b00, 2'b00, 1'b1));
    cyc("mdu2_c3", ev(C_MS,   2'b00, 2'b00, 1'b1));
    cyc("mdu2_c4", ev(C_NONE, 2'b00, 2'b00, 1'b1));
    clear_in();
    cyc("mdu_done", ev(C_NONE, 2'b00, 2'b00, 1'b0));

    // Memory wait with a taken branch frozen in E
    mem_req = 1'b1; pc_src_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("mw_wait%0d", i), ev(C_MW, 2'b00, 2'b00, 1'b0));
    end
    mem_ready = 1'b1;
    cyc("mw_ready_redirect", ev(C_RDIR, 2'b00, 2'b00, 1'b0));
    clear_in();
    cyc("mw_after", ev(C_NONE, 2'b00, 2'b00, 1'b0));

    // MDU overlapping memory waits: count runs on, exit waits for memory
    mdu_start = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    cyc("mdumw_c1", ev(C_MW, 2'b00, 2'b00, 1'b0));
    cyc("mdumw_c2", ev(C_MW, 2'b00, 2'b00, 1'b1));
    mem_ready = 1'b1;
    cyc("mdumw_c3", ev(C_MS, 2'b00, 2'b00, 1'b1));
    mem_ready = 1'b0;
    cyc("mdumw_c4_park", ev(C_MW, 2'b00, 2'b00, 1'b1));
    mem_ready = 1'b1;
    cyc("mdumw_c5", ev(C_NONE, 2'b00, 2'b00, 1'b1));
    clear_in();
    cyc("mdumw_done", ev(C_NONE, 2'b00, 2'b00, 1'b0));

    // MDU under load-use: load-use does not flush E while E is frozen
    mdu_start = 1'b1; res_src_e = 2'b01; rd_e = 5'd4; rs_d = 5'd4;
    cyc("mdulu_c1", ev(C_MS, 2'b00, 2'b00, 1'b0));
    res_src_e = 2'b00; rd_e = 5'd0; rs_d = 5'd0;
    cyc("mdulu_c2", ev(C_MS, 2'b00, 2'b00, 1'b1));

    // Reset while BUSY with cnt == 1; start still held by the datapath
    name_q.push_back("rst_mid_before");
    exp_q.push_back(ev(C_MS, 2'b00, 2'b00, 1'b1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", obs, ev(C_NONE, 2'b00, 2'b00, 1'b0));
    @(posedge clk);
    #1;
    cyc("rst_mid_hold", ev(C_NONE, 2'b00, 2'b00, 1'b0));
    clear_in();
    rst_n = 1'b1;
    cyc("rst_mid_release", ev(C_NONE, 2'b00, 2'b00, 1'b0));
`ifdef HAZARD_PERF_CNT_EN
    check32("perf_load_rst2", load_cnt, 32'd0);
    check32("perf_mdu_rst2", mdu_cnt, 32'd0);
    check32("perf_mem_rst2", mem_cnt, 32'd0);
    check32("perf_flush_rst2", flush_cnt, 32'd0);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Multi-cycle-aware hazard and forwarding controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Resolves RAW hazards by forwarding from M/W and by load-use stalls.
- Adds a sequential stall engine for a multi-cycle MDU in E and for variable-latency data memory in M.
- Resolves control hazards with flushes gated against frozen stages.
- Sits beside the datapath and drives every stage register's stall/flush input.

## Interface
- `REG_AW`, 5: register address width.
- `MDU_LAT`, 4: cycles an MDU instruction occupies E; legal range 2..64.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `RS_addrD_i`, `RT_addrD_i` in `REG_AW`: D-stage source registers.
- `RS_addrE_i`, `RT_addrE_i`, `RD_addrE_i` in `REG_AW`: E-stage source and destination registers.
- `ResultSrcE_i` in 2: E-stage result select; 2'b01 means load.
- `PC_SrcE_i` in 1: branch/jump taken in E.
- `MduStartE_i` in 1: E holds an MDU instruction; level, held while that instruction is in E.
- `RD_addrM_i` in `REG_AW`, `RegWriteM_i` in 1: M-stage writeback info.
- `MemReqM_i` in 1: M holds a load or store.
- `MemReadyM_i` in 1: data memory completes this cycle.
- `RD_addrW_i` in `REG_AW`, `RegWriteW_i` in 1: W-stage writeback info.
- `StallF_o`, `StallD_o`, `StallE_o`, `StallM_o` out 1: hold the stage register.
- `FlushD_o`, `FlushE_o`, `FlushM_o`, `FlushW_o` out 1: load a bubble into the stage register.
- `RedirectE_o` out 1: PC mux may take the branch target.
- `Forward1E_o`, `Forward2E_o` out 2: 00 register file, 01 W result, 10 M ALU result.
- `MduBusy_o` out 1: FSM is in `BUSY`.

## Operation
- **Forwarding**, combinational, per source register `s`:
  - 10 if `s == RD_addrM_i`, `RegWriteM_i` is set and `s != 0`.
  - Otherwise 01 if the same test holds against W.
  - Otherwise 00.
- **Load-use stall** (`lu`): `ResultSrcE_i == 01`, `RD_addrE_i != 0` and `RD_addrE_i` equals either D source.
  - Only loads stall. LUI/AUIPC/PC+4 results are forwarded and never stall.
- **Memory wait** (`mw`): `MemReqM_i & ~MemReadyM_i`.
- **MDU FSM**, state `IDLE`/`BUSY`, plus down-counter `cnt` of width `$clog2(MDU_LAT)`:
  - `IDLE` with `MduStartE_i`: `ms = 1`; next state `BUSY`, `cnt <= MDU_LAT-2`.
  - `BUSY`: `ms = (cnt != 0)`. `cnt` decrements each cycle while nonzero, including during `mw`.
  - `BUSY` with `cnt == 0` and `~mw`: next state `IDLE`. With `mw`, stay in `BUSY` holding `cnt == 0`.
  - `MduStartE_i` is ignored while in `BUSY`.
- **Stall/flush equations**:
  - `StallM_o = mw`, `FlushW_o = mw`.
  - `StallE_o = mw | ms`, `FlushM_o = ms & ~mw`.
  - `StallF_o = StallD_o = mw | ms | lu`.
  - `RedirectE_o = PC_SrcE_i & ~StallE_o`.
  - `FlushD_o = RedirectE_o`.
  - `FlushE_o = RedirectE_o | (lu & ~StallE_o)`.
- **Priority**: `mw` > `ms` > `lu` > redirect. A taken branch frozen in E redirects only in the cycle E advances.

## Timing
- **Reset**: state `IDLE`, `cnt` = 0, `MduBusy_o` = 0. With all inputs at 0, every output is 0.
- Forwarding, stalls and flushes are combinational from inputs and state. Only the FSM, `cnt` and the perf counters are registered.
- **MDU**: the instruction spends exactly `MDU_LAT` cycles in E when there is no `mw`. Stalls are asserted for `MDU_LAT-1` consecutive cycles, starting in the cycle `MduStartE_i` first rises.
- **Back-to-back MDU**: the second instruction enters E the cycle after the first leaves. It is seen in `IDLE` and starts a new sequence with no gap cycle.
- **Load-use**: exactly 1 stall cycle per occurrence, unless extended by `mw`/`ms`.
- **Reset mid-sequence**: immediate return to `IDLE`. Stalls drop asynchronously with the reset.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds four 32-bit wrapping output counters, all reset to 0:
  - `LoadStallCnt_o`: +1 per cycle with `lu & ~mw & ~ms`.
  - `MduStallCnt_o`: +1 per cycle with `ms & ~mw`.
  - `MemStallCnt_o`: +1 per cycle with `mw`.
  - `FlushCnt_o`: +1 per cycle with `RedirectE_o`.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Structure
- `hazard_pkg` holds:
  - Forward-select constants `FWD_RF`, `FWD_W`, `FWD_M`.
  - `RESULT_LOAD` = 2'b01.
  - MDU state enum `IDLE`/`BUSY`.
- One sub-module, `mdu_stall_ctr`: the FSM plus `cnt`. Inputs `start`, `mw`; outputs `ms`, `busy`. Parameter `MDU_LAT`.

## Test plan
- **Forwarding**: x5 written in both M and W, `RS_addrE_i` = 5 → `Forward1E_o` = 10. Drop `RegWriteM_i` → 01. `RS_addrE_i` = 0 with matching `RD_addrM_i` = 0 → 00.
- **Load-use**: load to x7 in E, `RT_addrD_i` = 7 → 1 cycle of `StallF_o`/`StallD_o`/`FlushE_o`.
  - `ResultSrcE_i` = 11 → no stall.
  - `RD_addrE_i` = 0 → no stall.
- **MDU**: `MDU_LAT` = 4, `MduStartE_i` held 4 cycles → `StallE_o`/`FlushM_o` high for 3 cycles.
  - `MduBusy_o` high for cycles 2–4.
  - Back-to-back second start gives 3 more stall cycles with no gap.
- **Memory wait**: `MemReqM_i` = 1 with `MemReadyM_i` low for 5 cycles → `StallF..M_o` and `FlushW_o` high for 5 cycles.
  - Taken branch in E during the wait: `RedirectE_o` = 0 until the first ready cycle, then 1 for one cycle together with `FlushD_o`/`FlushE_o`.
- **Reset**: deassert `rst_n_i` during `BUSY` with `cnt` = 1 → all stalls 0 immediately. After release, `MduBusy_o` = 0.
  - With `HAZARD_PERF_CNT_EN`, all counters read 0.
